// File: rtl/inst_cache_ctrl_pkg.sv
// Shared constants for the instruction cache controller: bus widths,
// reset polarity, default sizing and FSM state encodings.
package inst_cache_ctrl_pkg;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic        RstEnable   = 1'b0;   // reset is active-low
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam int ICACHE_LINE_NUM = 16;
    localparam int ICACHE_CNT_W    = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/inst_cache_ctrl_line_ram.sv
// Line storage for the instruction cache: {valid, tag, data} per line.
// Asynchronous read, synchronous write, one-cycle clear of all valid bits.
module icache_line_ram
    import inst_cache_ctrl_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM,
    parameter int IDX_W    = $clog2(LINE_NUM),
    parameter int TAG_W    = 30 - IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   widx_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [InstBus-1:0] wdata_i,
    input  logic [IDX_W-1:0]   ridx_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [InstBus-1:0] rdata_o
);

    logic [LINE_NUM-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [LINE_NUM];
    logic [InstBus-1:0]  data_q [LINE_NUM];

    // Valid bits: clear-all takes priority over a same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag/data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache bridging the core fetch
// port to a req/ack instruction bus. Hits answer combinationally; misses stall
// the core, fetch the word, install it and deliver it for one DONE cycle.
module inst_cache_ctrl
    import inst_cache_ctrl_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM,
    parameter int CNT_W    = ICACHE_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstBus-1:0]     rom_data_o,
    output logic                   stall_req_o,
    input  logic                   flush_i,
    output logic                   bus_req_o,
    output logic [InstAddrBus-1:0] bus_addr_o,
    input  logic                   bus_ack_i,
    input  logic [InstBus-1:0]     bus_data_i,
    output logic [CNT_W-1:0]       miss_cnt_o
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 30 - IDX_W;

    logic [1:0]             state_q, state_d;
    logic [InstAddrBus-1:0] miss_addr_q;
    logic [InstBus-1:0]     refill_q;
    logic                   discard_q;
    logic [CNT_W-1:0]       miss_cnt_q;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [InstBus-1:0] rd_data;
    logic               hit;
    logic               miss_start;
    logic               fill_we;

    assign idx = rom_addr_i[IDX_W+1:2];
    assign tag = rom_addr_i[31:IDX_W+2];
    assign hit = rd_valid && (rd_tag == tag);

    // A flush on the ack edge (or earlier in REQ) keeps the fill out of the array.
    assign fill_we = (state_q == ST_REQ) && bus_ack_i && !discard_q && !flush_i;

    icache_line_ram #(
        .LINE_NUM (LINE_NUM),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_line_ram (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (flush_i),
        .we_i     (fill_we),
        .widx_i   (miss_addr_q[IDX_W+1:2]),
        .wtag_i   (miss_addr_q[31:IDX_W+2]),
        .wdata_i  (bus_data_i),
        .ridx_i   (idx),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    // Next-state and output decode; outputs are forced idle while reset is held.
    always_comb begin
        state_d     = state_q;
        miss_start  = 1'b0;
        rom_data_o  = ZeroWord;
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        bus_addr_o  = ZeroWord;
        case (state_q)
            ST_IDLE: begin
                if (rom_ce_i == ChipEnable) begin
                    if (hit) begin
                        rom_data_o = rd_data;
                    end else begin
                        stall_req_o = 1'b1;
                        miss_start  = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_req_o = 1'b1;
                bus_req_o   = 1'b1;
                bus_addr_o  = miss_addr_q;
                if (bus_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rom_data_o = refill_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst == RstEnable) begin
            rom_data_o  = ZeroWord;
            stall_req_o = 1'b0;
            bus_req_o   = 1'b0;
            bus_addr_o  = ZeroWord;
        end
    end

    // FSM state, captured miss address, refill word, discard flag, miss counter.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= ZeroWord;
            refill_q    <= ZeroWord;
            discard_q   <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_addr_q <= rom_addr_i & 32'hFFFF_FFFC;
                miss_cnt_q  <= miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((state_q == ST_REQ) && bus_ack_i) begin
                refill_q <= bus_data_i;
            end
            if (state_q == ST_DONE) begin
                discard_q <= 1'b0;
            end else if ((state_q == ST_REQ) && flush_i) begin
                discard_q <= 1'b1;
            end
        end
    end

    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Self-checking bench for inst_cache_ctrl: directed scenarios plus randomized
// fetch traffic against a line-level cache model. A narrow miss counter is
// used so the wrap-around is exercised in a short run.
module tb_inst_cache_ctrl;

    localparam int CNT_W    = 4;
    localparam int LINE_NUM = 16;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        rom_ce_i   = 1'b0;
    logic [31:0] rom_addr_i = '0;
    logic        flush_i    = 1'b0;
    logic        bus_ack_i  = 1'b0;
    logic [31:0] bus_data_i = '0;
    logic [31:0] rom_data_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [CNT_W-1:0] miss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which word address each line holds, and its data.
    bit          m_valid [LINE_NUM];
    logic [29:0] m_word  [LINE_NUM];
    logic [31:0] m_data  [LINE_NUM];
    int          m_cnt;

    inst_cache_ctrl #(.LINE_NUM(LINE_NUM), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .stall_req_o (stall_req_o),
        .flush_i     (flush_i),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_data_i  (bus_data_i),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic m_flush();
        for (int i = 0; i < LINE_NUM; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_reset();
        m_flush();
        m_cnt = 0;
    endtask

    // One fetch from the core's point of view, checked cycle by cycle.
    // fl_idle: flush in the lookup cycle; fl_req: REQ cycle (1-based) to flush in, 0 = none.
    task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data,
                         input bit fl_idle, input int fl_req, input string name);
        int          idx;
        bit          hit;
        logic [31:0] exp_rd;
        int          stalls;
        idx    = int'(addr[5:2]);
        hit    = m_valid[idx] && (m_word[idx] == addr[31:2]);
        exp_rd = m_data[idx];
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
        flush_i    = fl_idle;
        @(negedge clk);
        n_tests++;
        if (hit) begin
            if (stall_req_o !== 1'b0 || bus_req_o !== 1'b0 || rom_data_o !== exp_rd) begin
                n_fail++;
                $display("FAIL %s hit: stall=%b req=%b data=%h, expected stall=0 req=0 data=%h",
                         name, stall_req_o, bus_req_o, rom_data_o, exp_rd);
            end
        end else if (stall_req_o !== 1'b1 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s miss lookup: stall=%b req=%b, expected stall=1 req=0",
                     name, stall_req_o, bus_req_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        if (fl_idle) m_flush();
        if (!hit) begin
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            stalls = 1;
            for (int k = 1; k <= lat; k++) begin
                if (k == lat) begin
                    bus_ack_i  = 1'b1;
                    bus_data_i = data;
                end else begin
                    bus_data_i = $urandom;
                end
                if (k == fl_req) flush_i = 1'b1;
                @(negedge clk);
                n_tests++;
                if (bus_req_o !== 1'b1 || stall_req_o !== 1'b1 || bus_addr_o !== (addr & 32'hFFFF_FFFC)) begin
                    n_fail++;
                    $display("FAIL %s req cycle %0d: req=%b stall=%b addr=%h, expected req=1 stall=1 addr=%h",
                             name, k, bus_req_o, stall_req_o, bus_addr_o, addr & 32'hFFFF_FFFC);
                end
                if (stall_req_o === 1'b1) stalls++;
                @(posedge clk); #1;
                bus_ack_i = 1'b0;
                flush_i   = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (stall_req_o !== 1'b0 || bus_req_o !== 1'b0 || rom_data_o !== data) begin
                n_fail++;
                $display("FAIL %s done: stall=%b req=%b data=%h, expected stall=0 req=0 data=%h",
                         name, stall_req_o, bus_req_o, rom_data_o, data);
            end
            n_tests++;
            if (stalls != lat + 1) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stalls, lat + 1);
            end
            if (fl_req > 0) begin
                m_flush();
            end else begin
                m_valid[idx] = 1'b1;
                m_word[idx]  = addr[31:2];
                m_data[idx]  = data;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (int'(miss_cnt_o) != m_cnt) begin
            n_fail++;
            $display("FAIL %s miss_cnt: got %0d, expected %0d", name, miss_cnt_o, m_cnt);
        end
    endtask

    task automatic test_reset();
        m_reset();
        rst        = 1'b0;
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h0000_0010;
        #3;
        n_tests++;
        if (rom_data_o !== 32'h0 || stall_req_o !== 1'b0 || bus_req_o !== 1'b0 ||
            bus_addr_o !== 32'h0 || miss_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: data=%h stall=%b req=%b addr=%h cnt=%0d, expected all zero",
                     rom_data_o, stall_req_o, bus_req_o, bus_addr_o, miss_cnt_o);
        end
        rom_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_0010, 3, 32'h3401_1100, 1'b0, 0, "cold_miss");
    endtask

    task automatic test_hit();
        fetch(32'h0000_0010, 1, 32'h0, 1'b0, 0, "hit_after_fill");
        fetch(32'h0000_0013, 1, 32'h0, 1'b0, 0, "hit_low_bits");
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0050, 2, 32'hAAAA_0050, 1'b0, 0, "conflict_new");
        fetch(32'h0000_0010, 2, 32'h3401_1100, 1'b0, 0, "conflict_old");
        n_tests++;
        if (miss_cnt_o !== 4'd3) begin
            n_fail++;
            $display("FAIL conflict_cnt: got %0d, expected 3", miss_cnt_o);
        end
    endtask

    task automatic test_flush_req();
        fetch(32'h0000_0020, 3, 32'hDEAD_BEEF, 1'b0, 1, "flush_req_fill");
        fetch(32'h0000_0020, 1, 32'hDEAD_BEEF, 1'b0, 0, "flush_req_refetch");
        fetch(32'h0000_0010, 1, 32'h3401_1100, 1'b0, 0, "flush_req_old_line");
        fetch(32'h0000_0030, 2, 32'h1234_5678, 1'b0, 2, "flush_on_ack");
        fetch(32'h0000_0030, 2, 32'h1234_5678, 1'b0, 0, "flush_on_ack_refetch");
    endtask

    task automatic test_flush_idle();
        fetch(32'h0000_0010, 1, 32'h0, 1'b1, 0, "flush_idle_hit");
        fetch(32'h0000_0010, 2, 32'h3401_1100, 1'b0, 0, "flush_idle_refetch");
    endtask

    task automatic test_reset_mid_refill();
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h0000_0060;
        @(posedge clk); #1;
        n_tests++;
        if (bus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_req: req=%b, expected 1", bus_req_o);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus_req_o !== 1'b0 || stall_req_o !== 1'b0 || miss_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: req=%b stall=%b cnt=%0d, expected 0 0 0",
                     bus_req_o, stall_req_o, miss_cnt_o);
        end
        m_reset();
        @(negedge clk);
        rst      = 1'b1;
        rom_ce_i = 1'b0;
        @(posedge clk); #1;
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h1111_1111;
        @(negedge clk);
        n_tests++;
        if (bus_req_o !== 1'b0 || stall_req_o !== 1'b0 || rom_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_late_ack: req=%b stall=%b data=%h, expected 0 0 0",
                     bus_req_o, stall_req_o, rom_data_o);
        end
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        fetch(32'h0000_0060, 2, 32'h2222_2222, 1'b0, 0, "rst_refetch");
    endtask

    task automatic test_disabled();
        int cnt0;
        cnt0     = m_cnt;
        rom_ce_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            rom_addr_i = $urandom;
            bus_ack_i  = 1'($urandom_range(0, 1));
            bus_data_i = $urandom;
            @(negedge clk);
            n_tests++;
            if (rom_data_o !== 32'h0 || stall_req_o !== 1'b0 || bus_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled cycle %0d: data=%h stall=%b req=%b, expected 0 0 0",
                         c, rom_data_o, stall_req_o, bus_req_o);
            end
            @(posedge clk); #1;
        end
        bus_ack_i = 1'b0;
        n_tests++;
        if (int'(miss_cnt_o) != cnt0) begin
            n_fail++;
            $display("FAIL disabled_cnt: got %0d, expected %0d", miss_cnt_o, cnt0);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          lat;
        int          flr;
        bit          fli;
        for (int n = 0; n < 300; n++) begin
            addr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
                   32'($urandom_range(0, 3));
            lat  = $urandom_range(1, 4);
            fli  = ($urandom_range(0, 15) == 0);
            flr  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0;
            fetch(addr, lat, $urandom, fli, flr, "random");
            if ($urandom_range(0, 7) == 0) begin
                rom_ce_i   = 1'b0;
                rom_addr_i = $urandom;
                @(negedge clk);
                n_tests++;
                if (rom_data_o !== 32'h0 || stall_req_o !== 1'b0 || bus_req_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_gap: data=%h stall=%b req=%b, expected 0 0 0",
                             rom_data_o, stall_req_o, bus_req_o);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_req();
        test_flush_idle();
        test_reset_mid_refill();
        test_disabled();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
